// File: rtl/mod_sub_pipe_pkg.sv
// Shared constants for the pipelined modular subtractor (operand width, fixed latency).
// Optional feature macro used by this block: MODSUB_RANGE_CHECK_EN.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 14
`endif
`ifndef MODSUB_LAT
`define MODSUB_LAT 2
`endif

package mod_sub_pipe_pkg;
  localparam int unsigned MODSUB_DATA_W = `DATA_SIZE_ARB;
  // Butterfly-level latency balancing relies on this matching the two register slices.
  localparam int unsigned MODSUB_LAT    = `MODSUB_LAT;
endpackage

// File: rtl/mod_sub_stage.sv
// Generic valid/ready register slice: loads on advance, holds on stall, clears on reset.
module mod_sub_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_adv,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  // Slice register; a bubble also zeroes the payload so an empty slice reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= {W{1'b0}};
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : {W{1'b0}};
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage modular subtractor out = (a - b) mod q with valid/ready handshake.
// Define MODSUB_RANGE_CHECK_EN to add out_err, flagging beats with a >= q or b >= q.
module mod_sub_pipe
  import mod_sub_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MODSUB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] NTTin0,
  input  logic [DATA_W-1:0] NTTin1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out
`ifdef MODSUB_RANGE_CHECK_EN
  ,
  output logic              out_err
`endif
);
`ifdef MODSUB_RANGE_CHECK_EN
  localparam int unsigned S1_W = 2 * DATA_W + 2;
  localparam int unsigned S2_W = DATA_W + 1;
`else
  localparam int unsigned S1_W = 2 * DATA_W + 1;
  localparam int unsigned S2_W = DATA_W;
`endif

  logic              w_adv1;
  logic              w_adv2;
  logic              w_s1_valid;
  logic              w_s2_valid;
  logic [S1_W-1:0]   w_s1_in;
  logic [S1_W-1:0]   w_s1_q;
  logic [S2_W-1:0]   w_s2_in;
  logic [S2_W-1:0]   w_s2_q;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W:0]   w_s1_diff;
  logic [DATA_W-1:0] w_s1_mod;
  logic [DATA_W-1:0] w_res;

  // A stage may load when it is empty or the stage after it is moving.
  assign w_adv2   = !w_s2_valid || out_ready;
  assign w_adv1   = !w_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  assign w_diff = {1'b0, NTTin0} - {1'b0, NTTin1};

`ifdef MODSUB_RANGE_CHECK_EN
  logic w_err;
  logic w_s1_err;
  logic w_s2_err;

  assign w_err   = (NTTin0 >= q) || (NTTin1 >= q);
  assign w_s1_in = {w_diff, q, w_err};
  assign {w_s1_diff, w_s1_mod, w_s1_err} = w_s1_q;
  assign w_s2_in = {w_res, w_s1_err};
  assign {out, w_s2_err} = w_s2_q;
  assign out_err = w_s2_err;
`else
  assign w_s1_in = {w_diff, q};
  assign {w_s1_diff, w_s1_mod} = w_s1_q;
  assign w_s2_in = w_res;
  assign out     = w_s2_q;
`endif

  // Borrow out of the subtraction means a < b: fold back into range by adding q.
  always_comb begin
    w_res = w_s1_diff[DATA_W-1:0];
    if (w_s1_diff[DATA_W]) begin
      w_res = w_s1_diff[DATA_W-1:0] + w_s1_mod;
    end else begin
      w_res = w_s1_diff[DATA_W-1:0];
    end
  end

  mod_sub_stage #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_adv1),
    .i_valid (in_valid),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .o_data  (w_s1_q)
  );

  mod_sub_stage #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_adv2),
    .i_valid (w_s1_valid),
    .i_data  (w_s2_in),
    .o_valid (w_s2_valid),
    .o_data  (w_s2_q)
  );

  assign out_valid = w_s2_valid;
endmodule

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe: queue-based reference model plus directed cases.
module tb_mod_sub_pipe;
  import mod_sub_pipe_pkg::*;

  localparam int W = 14;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           acc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] q;
  logic [W-1:0] NTTin0;
  logic [W-1:0] NTTin1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
`ifdef MODSUB_RANGE_CHECK_EN
  logic         out_err;
`endif

  exp_t mq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  bit   rand_ordy = 1'b0;

  mod_sub_pipe #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .NTTin0    (NTTin0),
    .NTTin1    (NTTin1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef MODSUB_RANGE_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // (a - b) mod q by plain integer arithmetic, then kept to W bits.
  function automatic logic [W-1:0] model_res(input int a, input int b, input int qq);
    int r;
    r = a - b;
    if (r < 0) r = r + qq;
    return W'(r);
  endfunction

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model queue.
  initial begin
    bit   exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        run = 0;
      end else begin
        exp_v = (mq.size() > 0) && ((cyc - mq[0].acc) >= int'(MODSUB_LAT));
        chk(out_valid == exp_v, "out_valid", int'(out_valid), int'(exp_v));
        chk(in_ready == ((mq.size() < 2) || out_ready), "in_ready", int'(in_ready),
            int'((mq.size() < 2) || out_ready));
        if (out_valid && exp_v) begin
          chk(out == mq[0].res, "out_data", int'(out), int'(mq[0].res));
`ifdef MODSUB_RANGE_CHECK_EN
          chk(out_err == mq[0].err, "out_err", int'(out_err), int'(mq[0].err));
`endif
          if (out_ready) void'(mq.pop_front());
        end
`ifdef MODSUB_RANGE_CHECK_EN
        if (!out_valid) chk(out_err == 1'b0, "out_err_idle", int'(out_err), 0);
`endif
        if (out_valid) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (in_valid && in_ready) begin
          e.res = model_res(int'(NTTin0), int'(NTTin1), int'(q));
          e.err = (NTTin0 >= q) || (NTTin1 >= q);
          e.acc = cyc;
          mq.push_back(e);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive(input int a, input int b, input int qq);
    in_valid = 1'b1;
    NTTin0   = W'(a);
    NTTin1   = W'(b);
    q        = W'(qq);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 64) begin
        chk(1'b0, "accept_timeout", n, 64);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int qq);
    drive(a, b, qq);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (mq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(mq.size() == 0, "drain", mq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Isolated beat on an empty pipe with out_ready high: exact latency and literal result.
  task automatic single(input int a, input int b, input int qq, input int exp, input bit exp_err);
    send(a, b, qq);
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "lat_early", int'(out_valid), 0);
    @(negedge clk);
    chk(out_valid == 1'b1, "lat_exact", int'(out_valid), 1);
    chk(int'(out) == exp, "directed_out", int'(out), exp);
`ifdef MODSUB_RANGE_CHECK_EN
    chk(out_err == exp_err, "directed_err", int'(out_err), int'(exp_err));
`else
    if (exp_err) chk(1'b0, "err_case_without_feature", 1, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a;
    int b;
    int qq;
    int sel;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q         = 14'd0;
    NTTin0    = 14'd0;
    NTTin1    = 14'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    chk(out == 14'd0, "reset_out", int'(out), 0);
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    single(5, 3, 12289, 2, 1'b0);
    single(3, 5, 12289, 12287, 1'b0);
    single(0, 12288, 12289, 1, 1'b0);
    single(100, 100, 12289, 0, 1'b0);
    single(1, 2, 12289, 12288, 1'b0);
    single(1, 2, 7681, 7680, 1'b0);
`ifdef MODSUB_RANGE_CHECK_EN
    single(12289, 0, 12289, 12289, 1'b1);
    single(12288, 0, 12289, 12288, 1'b0);
`endif

    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      send($urandom_range(0, 12288), $urandom_range(0, 12288), 12289);
    end
    drain();
    chk(max_run == 16, "back_to_back_run", max_run, 16);

    out_ready = 1'b0;
    send(10, 4, 12289);
    send(20, 30, 12289);
    drive(7, 9, 7681);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
      chk(out_valid == 1'b1 && out == 14'd6, "bp_hold", int'(out), 6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    out_ready = 1'b0;
    send(1, 1, 12289);
    send(2, 1, 12289);
    in_valid = 1'b0;
    @(negedge clk);
    chk(in_ready == 1'b0, "full_before_reset", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk(out_valid == 1'b0, "midreset_out_valid", int'(out_valid), 0);
    chk(out == 14'd0, "midreset_out", int'(out), 0);
    @(posedge clk);
    #1;

    rand_ordy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       qq = 12289;
        1:       qq = 7681;
        2:       qq = 3329;
        default: qq = $urandom_range(1, 16383);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 16383);
        b = $urandom_range(0, 16383);
      end else begin
        a = $urandom_range(0, qq - 1);
        b = $urandom_range(0, qq - 1);
      end
      send(a, b, qq);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    rand_ordy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
